// File: rtl/ps2_rx_deserializer.sv
// rtl/ps2_rx_deserializer.sv - PS/2 device-to-host frame receiver with ready flag and gated level irq
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   ireIn         in   new interrupt-enable value
//   configLoadEn  in   1-cycle strobe, loads ire from ireIn
//   dataReadReq   in   1-cycle strobe, software read of the data register (clears ready)
//   data          out  last committed data byte
//   parity        out  parity bit received with data, raw from the wire
//   ready         out  unread byte available
//   ire           out  interrupt enable
//   irq           out  interrupt request, ire & ready
//   ps2Clk        in   asynchronous PS/2 clock pin
//   ps2Data       in   asynchronous PS/2 data pin
module ps2_rx_deserializer #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ireIn,
    input  logic       configLoadEn,
    input  logic       dataReadReq,
    output logic [7:0] data,
    output logic       parity,
    output logic       ready,
    output logic       ire,
    output logic       irq,
    input  logic       ps2Clk,
    input  logic       ps2Data
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [FW-1:0] r_fcnt;
    logic          r_filt;
    logic          r_filt_q;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_sh;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_data;
    logic          r_parity;

    logic          r_ready;
    logic          r_ire;
    logic          r_irq;

    logic          w_fall;
    logic          w_sample;
    logic          w_timeout;
    logic          w_commit;
    logic          w_ready_nxt;
    logic          w_ire_nxt;

    // Synchronisers idle high so a reset does not look like a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2Clk};
            r_dat_sync <= {r_dat_sync[0], ps2Data};
        end
    end

    // Deglitch: the filtered clock follows only after FILTER_LEN consecutive
    // mismatching cycles; any agreement in between restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fcnt   <= '0;
            r_filt   <= 1'b1;
            r_filt_q <= 1'b1;
        end else begin
            r_filt_q <= r_filt;
            if (r_clk_sync[1] != r_filt) begin
                if (r_fcnt == FCNT_LAST) begin
                    r_filt <= r_clk_sync[1];
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall    = r_filt_q & ~r_filt;
    assign w_sample  = r_dat_sync[1];
    assign w_timeout = (r_state != S_IDLE) && (r_tcnt == TO_LAST);
    assign w_commit  = w_fall && !w_timeout && (r_state == S_STOP) && w_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par_sh <= 1'b0;
            r_tcnt   <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
        end else begin
            // Bit-gap counter saturates so a stalled frame cannot wrap back below the limit.
            if (r_state == S_IDLE || w_fall) begin
                r_tcnt <= '0;
            end else if (r_tcnt != TO_LAST) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_timeout) begin
                r_state <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_sample) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift[r_bitcnt] <= w_sample;
                        r_bitcnt          <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par_sh <= w_sample;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        // Bad stop bit drops the frame silently.
                        if (w_sample) begin
                            r_data   <= r_shift;
                            r_parity <= r_par_sh;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Commit beats a coincident read so the freshly arrived byte is not lost.
    always_comb begin
        w_ready_nxt = r_ready;
        if (w_commit) begin
            w_ready_nxt = 1'b1;
        end else if (dataReadReq) begin
            w_ready_nxt = 1'b0;
        end
        w_ire_nxt = configLoadEn ? ireIn : r_ire;
    end

    // irq is built from the next-state values so it lines up with ready/ire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_ire   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_ire   <= w_ire_nxt;
            r_irq   <= w_ready_nxt & w_ire_nxt;
        end
    end

    assign data   = r_data;
    assign parity = r_parity;
    assign ready  = r_ready;
    assign ire    = r_ire;
    assign irq    = r_irq;

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// tb/tb_ps2_rx_deserializer.sv - self-checking bench for ps2_rx_deserializer
module tb_ps2_rx_deserializer;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       ireIn;
    logic       configLoadEn;
    logic       dataReadReq;
    logic [7:0] data;
    logic       parity;
    logic       ready;
    logic       ire;
    logic       irq;
    logic       ps2Clk;
    logic       ps2Data;

    int n_pass;
    int n_total;

    ps2_rx_deserializer #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ireIn        (ireIn),
        .configLoadEn (configLoadEn),
        .dataReadReq  (dataReadReq),
        .data         (data),
        .parity       (parity),
        .ready        (ready),
        .ire          (ire),
        .irq          (irq),
        .ps2Clk       (ps2Clk),
        .ps2Data      (ps2Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ire;
        logic       rd_before;
        logic       rd_after;
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_par;
        logic       exp_rdy;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    task automatic pulse_read();
        @(posedge clk); #1 dataReadReq = 1'b1;
        @(posedge clk); #1 dataReadReq = 1'b0;
    endtask

    task automatic load_ire(input logic v);
        @(posedge clk); #1 ireIn = v; configLoadEn = 1'b1;
        @(posedge clk); #1 configLoadEn = 1'b0;
    endtask

    // Sends the first nbits of a frame; optional short low glitch after bit glitch_after.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int glitch_after);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2Data = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2Clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 ps2Clk = 1'b1;
            if (i == glitch_after) begin
                repeat (HALF / 2) @(posedge clk);
                #1 ps2Clk = 1'b0;
                repeat (FL - 1) @(posedge clk);
                #1 ps2Clk = 1'b1;
            end
        end
        @(posedge clk); #1 ps2Data = 1'b1;
        repeat (4 * HALF) @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        ireIn        = 1'b0;
        configLoadEn = 1'b0;
        dataReadReq  = 1'b0;
        ps2Clk       = 1'b1;
        ps2Data      = 1'b1;

        //           ire   rd_b  rd_a  d      par   stop  e_data e_par e_rdy e_irq
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b1, 8'h29, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk8("rst_data", data, 8'h00);
        chk1("rst_parity", parity, 1'b0);
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_ire", ire, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            load_ire(vecs[i].ire);
            if (vecs[i].rd_before) pulse_read();
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, 11, -1);
            chk8($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            chk1($sformatf("vec%0d_parity", i), parity, vecs[i].exp_par);
            chk1($sformatf("vec%0d_ready", i), ready, vecs[i].exp_rdy);
            chk1($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
            if (vecs[i].rd_after) begin
                pulse_read();
                chk1($sformatf("vec%0d_read_ready", i), ready, 1'b0);
                chk1($sformatf("vec%0d_read_irq", i), irq, 1'b0);
            end
        end

        // Read strobe held through the commit of 0x33: commit must win.
        @(posedge clk); #1 dataReadReq = 1'b1;
        fork
            send_frame(8'h33, 1'b1, 1'b1, 11, -1);
            begin : mon
                int n;
                n = 0;
                while (data !== 8'h33 && n < 2000) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk1("overlap_ready_at_commit", ready, 1'b1);
                dataReadReq = 1'b0;
            end
        join
        chk8("overlap_data", data, 8'h33);
        chk1("overlap_parity", parity, 1'b1);
        chk1("overlap_ready", ready, 1'b1);

        // Partial frame abandoned by the device, then a clean frame.
        pulse_read();
        send_frame(8'hFF, 1'b1, 1'b1, 5, -1);
        repeat (TO + 50) @(posedge clk);
        #1;
        chk1("timeout_ready", ready, 1'b0);
        chk8("timeout_data_held", data, 8'h33);
        send_frame(8'h76, 1'b0, 1'b1, 11, -1);
        chk8("after_timeout_data", data, 8'h76);
        chk1("after_timeout_parity", parity, 1'b0);
        chk1("after_timeout_ready", ready, 1'b1);

        // Clock glitch one cycle shorter than the filter window mid-frame.
        pulse_read();
        send_frame(8'h12, 1'b1, 1'b1, 11, 3);
        chk8("glitch_data", data, 8'h12);
        chk1("glitch_parity", parity, 1'b1);
        chk1("glitch_ready", ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
